// File: rtl/cdc_fifo_pkg.sv
// rtl/cdc_fifo_pkg.sv - shared Gray-code helpers and limits for the dual-clock FIFO
package cdc_fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Helpers work at this width; callers zero-extend in and truncate out with casts.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// rtl/cdc_sync_bus.sv - multi-stage flop synchronizer for a Gray-coded bus
module cdc_sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // First stage may go metastable; the rest only resolve it. No logic between stages.
    logic [WIDTH-1:0] cdc_meta_q;
    logic [WIDTH-1:0] stage_q [STAGES-1];

    // Shift the incoming bus through the chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cdc_meta_q <= '0;
            for (int i = 0; i < STAGES - 1; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            cdc_meta_q <= d_i;
            stage_q[0] <= cdc_meta_q;
            for (int i = 1; i < STAGES - 1; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-2];

endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// rtl/cdc_fifo_rd_ctrl.sv - FIFO read-domain controller; optional level port under CDC_FIFO_RD_LEVEL_EN
module cdc_fifo_rd_ctrl
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int PW         = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PW-1:0]     cdc_wptr_gray_i,
    output logic [PW-1:0]     rptr_gray_o,
    output logic              re_o,
    output logic [AW-1:0]     raddr_o,
    input  logic [DATA_W-1:0] core_rdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [DATA_W-1:0] rdata_o,
`ifdef CDC_FIFO_RD_LEVEL_EN
    output logic [PW-1:0]     rlevel_o,
`endif
    output logic              empty_o
);

    localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [PW-1:0]     wptr_sync;
    logic [PW-1:0]     rptr_bin_q, rptr_gray_q, rptr_bin_inc;
    logic              infl_q;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic              empty, pop, push, re;
    logic [2:0]        budget;

    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_N)) u_wptr_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cdc_wptr_gray_i),
        .q_o   (wptr_sync)
    );

    assign empty        = (rptr_gray_q == wptr_sync);
    assign pop          = (occ_q != 2'd0) & rready_i;
    assign push         = infl_q;
    assign rptr_bin_inc = rptr_bin_q + 1'b1;

    // Words the buffer will hold after this cycle; a new read may only go out if a slot remains.
    assign budget = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign re     = !empty && (budget < 3'd2);

    // Read pointer (binary and Gray) and the in-flight flag for the core's read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            infl_q      <= 1'b0;
        end else begin
            infl_q <= re;
            if (re) begin
                rptr_bin_q  <= rptr_bin_inc;
                rptr_gray_q <= PW'(bin2gray(GRAY_MAX_W'(rptr_bin_inc)));
            end
        end
    end

    // Two-entry output buffer next state: head feeds the stream, tail catches the overflow word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = core_rdata_i;
                else               tail_d = core_rdata_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = core_rdata_i;
                end else begin
                    head_d = tail_q;
                    tail_d = core_rdata_i;
                end
            end
            default: ;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

`ifdef CDC_FIFO_RD_LEVEL_EN
    logic [PW-1:0] rlevel_q;

    // Words still held in the core as seen from this domain; lags the true writer count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rlevel_q <= '0;
        else       rlevel_q <= PW'(gray2bin(GRAY_MAX_W'(wptr_sync))) - rptr_bin_q;
    end

    assign rlevel_o = rlevel_q;
`endif

    assign rptr_gray_o = rptr_gray_q;
    assign re_o        = re;
    assign raddr_o     = rptr_bin_q[AW-1:0];
    assign rvalid_o    = (occ_q != 2'd0);
    assign rdata_o     = head_q;
    assign empty_o     = empty;

endmodule

// File: tb/tb_cdc_fifo_rd_ctrl.sv
// tb/tb_cdc_fifo_rd_ctrl.sv - self-checking bench for cdc_fifo_rd_ctrl
module tb_cdc_fifo_rd_ctrl;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int PW     = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PW-1:0]     wptr_gray = '0;
    logic [PW-1:0]     rptr_gray;
    logic              re;
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] core_rdata = '0;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [DATA_W-1:0] rdata;
    logic              empty;
`ifdef CDC_FIFO_RD_LEVEL_EN
    logic [PW-1:0]     rlevel;
`endif

    cdc_fifo_rd_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cdc_wptr_gray_i (wptr_gray),
        .rptr_gray_o     (rptr_gray),
        .re_o            (re),
        .raddr_o         (raddr),
        .core_rdata_i    (core_rdata),
        .rvalid_o        (rvalid),
        .rready_i        (rready),
        .rdata_o         (rdata),
`ifdef CDC_FIFO_RD_LEVEL_EN
        .rlevel_o        (rlevel),
`endif
        .empty_o         (empty)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                tests = 0;
    int                fails = 0;
    int                wr_total = 0;
    int                rd_issued = 0;
    int                popped = 0;
    logic [PW-1:0]     wr_bin = '0;
    logic [PW-1:0]     prev_gray = '0;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Storage core: one-cycle registered read.
    always @(posedge clk) begin
        if (re) core_rdata <= mem[raddr];
    end

    // Stream scoreboard and protocol invariants.
    always @(negedge clk) begin
        if (rst) begin
            rd_issued = 0;
            popped    = 0;
            prev_gray = '0;
        end else begin
            if (re) begin
                check("re_while_empty", empty, 0);
                check("raddr_seq", raddr, rd_issued % DEPTH);
                rd_issued++;
            end
            if (rvalid && rready) begin
                check("pop_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("rdata_order", rdata, exp_q.pop_front());
                popped++;
            end
            check("inflight_bound", (rd_issued - popped) <= 2, 1);
            if (rptr_gray != prev_gray)
                check("gray_one_bit", $countones(rptr_gray ^ prev_gray), 1);
            prev_gray = rptr_gray;
`ifdef CDC_FIFO_RD_LEVEL_EN
            check("level_range", rlevel <= DEPTH, 1);
`endif
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        wptr_gray = '0;
        wr_bin    = '0;
        wr_total  = 0;
        rready    = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        int guard = 0;
        while ((wr_total - popped) >= DEPTH && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) check("push_space_timeout", guard, 0);
        mem[wr_bin[AW-1:0]] = d;
        exp_q.push_back(d);
        wr_bin    = wr_bin + 1'b1;
        wr_total++;
        wptr_gray = to_gray(wr_bin);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c = 0;
        while (popped < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_count", popped, n);
    endtask

    int c, c2, n_re, n_rv, f_re, l_re, f_rv, l_rv;
    int max_lvl;
    logic [PW-1:0] gexp;

    initial begin
        // 1: reset state, during and after
        #3;
        check("rst_empty", empty, 1);
        check("rst_re", re, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rptr_gray", rptr_gray, 0);
        check("rst_rdata", rdata, 0);
        do_reset();
        @(negedge clk);
        check("post_rst_empty", empty, 1);
        check("post_rst_re", re, 0);
        check("post_rst_rvalid", rvalid, 0);
        check("post_rst_rptr_gray", rptr_gray, 0);
`ifdef CDC_FIFO_RD_LEVEL_EN
        check("post_rst_level", rlevel, 0);
`endif

        // 2: single-word latency
        @(posedge clk); #1;
        push_word({$urandom, $urandom});
        c = 0;
        @(negedge clk);
        while (!re && c < 10) begin @(negedge clk); c++; end
        check("re_latency", c, 2);
        check("first_raddr", raddr, 0);
        c2 = 0;
        while (!rvalid && c2 < 10) begin @(negedge clk); c2++; end
        check("rvalid_latency", c2, 2);
        check("first_rdata", rdata, mem[0]);

        // 3: eight words streamed back to back
        do_reset();
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom});
        n_re = 0; n_rv = 0; f_re = -1; l_re = -1; f_rv = -1; l_rv = -1; max_lvl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (re)     begin n_re++; if (f_re < 0) f_re = i; l_re = i; end
            if (rvalid) begin n_rv++; if (f_rv < 0) f_rv = i; l_rv = i; end
`ifdef CDC_FIFO_RD_LEVEL_EN
            if (int'(rlevel) > max_lvl) max_lvl = int'(rlevel);
`endif
        end
        check("burst_re_count", n_re, 8);
        check("burst_re_span", l_re - f_re + 1, 8);
        check("burst_rv_count", n_rv, 8);
        check("burst_rv_span", l_rv - f_rv + 1, 8);
        check("burst_popped", popped, 8);
        check("burst_rptr_gray", rptr_gray, 5'b01100);
        check("burst_empty", empty, 1);
`ifdef CDC_FIFO_RD_LEVEL_EN
        check("burst_level_peak", max_lvl, 8);
        check("burst_level_end", rlevel, 0);
`endif

        // 4: back-pressure stalls after two reads, then drains without gaps
        do_reset();
        rready = 1'b0;
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom});
        n_re = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (re) n_re++;
        end
        check("bp_re_count", n_re, 2);
        check("bp_rvalid", rvalid, 1);
        check("bp_rdata_hold", rdata, exp_q[0]);
        @(negedge clk);
        check("bp_rdata_hold2", rdata, exp_q[0]);
`ifdef CDC_FIFO_RD_LEVEL_EN
        check("bp_level", rlevel, 6);
`endif
        @(posedge clk); #1;
        rready = 1'b1;
        n_rv = 0; f_rv = -1; l_rv = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (rvalid && rready) begin n_rv++; if (f_rv < 0) f_rv = i; l_rv = i; end
        end
        check("bp_pop_count", n_rv, 8);
        check("bp_pop_span", l_rv - f_rv + 1, 8);
        check("bp_popped", popped, 8);

        // 5: 40 random words across the pointer wrap with random back-pressure
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push_word({$urandom, $urandom});
            @(posedge clk); #1;
            rready = ($urandom_range(0, 3) != 0);
        end
        rready = 1'b1;
        wait_pops(40, 500);
        repeat (6) @(posedge clk);
        @(negedge clk);
        gexp = to_gray(5'd8);
        check("wrap_empty", empty, 1);
        check("wrap_rvalid", rvalid, 0);
        check("wrap_rptr_gray", rptr_gray, gexp);
        check("wrap_reads", rd_issued, 40);

        // 6: asynchronous reset mid-stream
        do_reset();
        rready = 1'b0;
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom});
        repeat (8) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_rvalid", rvalid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_re", re, 0);
        check("async_rst_rvalid", rvalid, 0);
        check("async_rst_rptr_gray", rptr_gray, 0);
        check("async_rst_raddr", raddr, 0);
        check("async_rst_rdata", rdata, 0);
        check("async_rst_empty", empty, 1);
`ifdef CDC_FIFO_RD_LEVEL_EN
        check("async_rst_level", rlevel, 0);
`endif
        do_reset();
        repeat (4) @(negedge clk);
        check("final_rvalid", rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
